// File: rtl/vlen_pkg.sv
// Shared constants and types for the vector-length scheduler.
package vlen_pkg;
  localparam int XW          = 12;
  localparam int LW          = 16;
  localparam int NREQ_DEF    = 4;
  localparam int DEPTH_DEF   = 8;
  localparam int TMO_CYC_DEF = 64;

  typedef logic [$clog2(NREQ_DEF)-1:0] req_id_t;

  // Index width that stays legal for a single requester.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/vlen_sched_rr_arb.sv
// Round-robin selector: one-hot grant to the first request at or after ptr.
module rr_arb #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  logic w_found;
  logic w_take;

  // Walk the requesters starting at ptr and keep the first hit.
  always_comb begin
    gnt     = {N{1'b0}};
    w_found = 1'b0;
    w_take  = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        w_take  = req[j] & ~w_found & (((int'(ptr) + k) % N) == j);
        gnt[j]  = gnt[j] | w_take;
        w_found = w_found | w_take;
      end
    end
  end
endmodule

// File: rtl/vlen_sched.sv
// Shares one vector-length datapath among NREQ requesters with in-order tag return.
// Optional watchdog enabled by defining VLEN_SCHED_WATCHDOG_EN.
module vlen_sched
  import vlen_pkg::*;
#(
  parameter  int NREQ    = NREQ_DEF,
  parameter  int DEPTH   = DEPTH_DEF,
  parameter  int TMO_CYC = TMO_CYC_DEF,
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XW-1:0]   req_x,
  input  logic [NREQ*XW-1:0]   req_y,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [LW-1:0]        rsp_len,
  output logic                 dp_en,
  output logic [XW-1:0]        dp_x,
  output logic [XW-1:0]        dp_y,
  input  logic                 dp_valid,
  input  logic [LW-1:0]        dp_len,
  output logic [CW-1:0]        inflight,
  output logic                 busy,
  output logic                 err_spur,
  output logic                 err_tmo
);
  localparam int IW = id_w(NREQ);
  localparam int PW = $clog2(DEPTH);

  logic [IW-1:0]   r_rr_ptr;
  logic [IW-1:0]   r_tag [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_inflight;
  logic [NREQ-1:0] r_rsp_valid;
  logic [LW-1:0]   r_rsp_len;
  logic            r_dp_en;
  logic [XW-1:0]   r_dp_x;
  logic [XW-1:0]   r_dp_y;
  logic            r_err_spur;

  logic [NREQ-1:0] w_gnt;
  logic [NREQ-1:0] w_rsp_oh;
  logic [IW-1:0]   w_gnt_id;
  logic [IW-1:0]   w_head;
  logic [XW-1:0]   w_x;
  logic [XW-1:0]   w_y;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_push;
  logic            w_can;
  logic            w_wd_hit;

  rr_arb #(.N(NREQ), .IW(IW)) u_arb (
    .req (req_valid),
    .ptr (r_rr_ptr),
    .gnt (w_gnt)
  );

  assign w_full  = (r_inflight == CW'(DEPTH));
  assign w_empty = (r_inflight == {CW{1'b0}});
  assign w_pop   = dp_valid & ~w_empty;
  assign w_head  = r_tag[r_rd_ptr];
  // A full FIFO may still accept when a result frees a slot this cycle.
  assign w_can   = (~w_full | dp_valid) & ~w_wd_hit & ~rst;
  assign w_push  = |(req_valid & req_ready);

  // Gate the grant and decode the winner's id, operands and response strobe.
  always_comb begin
    req_ready = {NREQ{1'b0}};
    w_gnt_id  = {IW{1'b0}};
    w_x       = {XW{1'b0}};
    w_y       = {XW{1'b0}};
    w_rsp_oh  = {NREQ{1'b0}};
    if (w_can) begin
      req_ready = w_gnt;
    end else begin
      req_ready = {NREQ{1'b0}};
    end
    for (int i = 0; i < NREQ; i++) begin
      w_gnt_id    = w_gnt_id | (req_ready[i] ? IW'(i) : {IW{1'b0}});
      w_x         = w_x | (req_ready[i] ? req_x[i*XW +: XW] : {XW{1'b0}});
      w_y         = w_y | (req_ready[i] ? req_y[i*XW +: XW] : {XW{1'b0}});
      w_rsp_oh[i] = (w_head == IW'(i));
    end
  end

  // Tag storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag[r_wr_ptr] <= w_gnt_id;
    end
  end

  // Arbitration pointer, FIFO pointers, issue and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= {IW{1'b0}};
      r_wr_ptr    <= {PW{1'b0}};
      r_rd_ptr    <= {PW{1'b0}};
      r_inflight  <= {CW{1'b0}};
      r_rsp_valid <= {NREQ{1'b0}};
      r_rsp_len   <= {LW{1'b0}};
      r_dp_en     <= 1'b0;
      r_dp_x      <= {XW{1'b0}};
      r_dp_y      <= {XW{1'b0}};
      r_err_spur  <= 1'b0;
    end else begin
      r_dp_en     <= w_push;
      r_rsp_valid <= w_pop ? w_rsp_oh : {NREQ{1'b0}};
      r_err_spur  <= r_err_spur | (dp_valid & w_empty);
      if (w_pop) begin
        r_rsp_len <= dp_len;
        r_rd_ptr  <= r_rd_ptr + PW'(1);
      end else begin
        r_rsp_len <= r_rsp_len;
        r_rd_ptr  <= w_wd_hit ? r_wr_ptr : r_rd_ptr;
      end
      if (w_push) begin
        r_dp_x   <= w_x;
        r_dp_y   <= w_y;
        r_wr_ptr <= r_wr_ptr + PW'(1);
        r_rr_ptr <= (w_gnt_id == IW'(NREQ - 1)) ? {IW{1'b0}} : w_gnt_id + IW'(1);
      end else begin
        r_dp_x   <= r_dp_x;
        r_dp_y   <= r_dp_y;
        r_wr_ptr <= r_wr_ptr;
        r_rr_ptr <= r_rr_ptr;
      end
      if (w_wd_hit) begin
        r_inflight <= {CW{1'b0}};
      end else begin
        case ({w_push, w_pop})
          2'b10:   r_inflight <= r_inflight + CW'(1);
          2'b01:   r_inflight <= r_inflight - CW'(1);
          default: r_inflight <= r_inflight;
        endcase
      end
    end
  end

`ifdef VLEN_SCHED_WATCHDOG_EN
  localparam int WW = $clog2(TMO_CYC + 1);

  logic [WW-1:0] r_wd;
  logic          r_err_tmo;

  // Grants are held off in the expiry cycle so the flush leaves nothing orphaned.
  assign w_wd_hit = (r_wd == WW'(TMO_CYC - 1)) & ~w_empty & ~dp_valid;

  // Watchdog counts stalled cycles while anything is outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd      <= {WW{1'b0}};
      r_err_tmo <= 1'b0;
    end else if (w_empty || dp_valid || w_wd_hit) begin
      r_wd      <= {WW{1'b0}};
      r_err_tmo <= r_err_tmo | w_wd_hit;
    end else begin
      r_wd      <= r_wd + WW'(1);
      r_err_tmo <= r_err_tmo;
    end
  end

  assign err_tmo = r_err_tmo;
`else
  assign w_wd_hit = 1'b0;
  assign err_tmo  = 1'b0;
`endif

  assign rsp_valid = r_rsp_valid;
  assign rsp_len   = r_rsp_len;
  assign dp_en     = r_dp_en;
  assign dp_x      = r_dp_x;
  assign dp_y      = r_dp_y;
  assign inflight  = r_inflight;
  assign err_spur  = r_err_spur;
  assign busy      = ~w_empty | (|req_valid);
endmodule

// File: tb/tb_vlen_sched.sv
// Self-checking bench for vlen_sched: directed table, corner sequences, random vs queue model.
module tb_vlen_sched;
  import vlen_pkg::*;

  localparam int NR  = 4;
  localparam int DP  = 8;
  localparam int TMO = 64;
`ifdef VLEN_SCHED_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req_valid;
  logic [3:0]    req_ready;
  logic [47:0]   req_x;
  logic [47:0]   req_y;
  logic [3:0]    rsp_valid;
  logic [15:0]   rsp_len;
  logic          dp_en;
  logic [11:0]   dp_x;
  logic [11:0]   dp_y;
  logic          dp_valid;
  logic [15:0]   dp_len;
  logic [3:0]    inflight;
  logic          busy;
  logic          err_spur;
  logic          err_tmo;

  always #5 clk = ~clk;

  vlen_sched #(.NREQ(NR), .DEPTH(DP), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .rsp_valid(rsp_valid), .rsp_len(rsp_len),
    .dp_en(dp_en), .dp_x(dp_x), .dp_y(dp_y), .dp_valid(dp_valid), .dp_len(dp_len),
    .inflight(inflight), .busy(busy), .err_spur(err_spur), .err_tmo(err_tmo)
  );

  int n_pass = 0;
  int n_tot  = 0;

  // Reference model state: tags outstanding in issue order plus expected registered outputs.
  int          q[$];
  int          m_rr   = 0;
  int          m_wd   = 0;
  logic        m_spur = 1'b0;
  logic        m_tmo  = 1'b0;
  logic [3:0]  m_rsp  = 4'd0;
  logic [15:0] m_len  = 16'd0;
  logic        m_dpen = 1'b0;
  logic [11:0] m_dpx  = 12'd0;
  logic [11:0] m_dpy  = 12'd0;
  logic [3:0]  last_ready;

  typedef struct {
    bit          rst;
    logic [3:0]  rv;
    logic [11:0] x;
    logic [11:0] y;
    bit          dv;
    logic [15:0] dl;
    logic [3:0]  e_ready;
    bit          e_dpen;
    logic [3:0]  e_rsp;
    logic [15:0] e_len;
    logic [3:0]  e_infl;
    bit          e_spur;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, logic [3:0] rv, logic [11:0] x, logic [11:0] y,
                              bit dv, logic [15:0] dl, logic [3:0] er, bit ede,
                              logic [3:0] ersp, logic [15:0] elen, logic [3:0] einf, bit esp);
    vec_t v;
    v.rst = r; v.rv = rv; v.x = x; v.y = y; v.dv = dv; v.dl = dl;
    v.e_ready = er; v.e_dpen = ede; v.e_rsp = ersp; v.e_len = elen;
    v.e_infl = einf; v.e_spur = esp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, check combinational grant, clock, check registered state.
  task automatic cyc(input bit r, input logic [3:0] rv, input logic [47:0] xs,
                     input logic [47:0] ys, input bit dv, input logic [15:0] dl,
                     output int gid);
    int   sz;
    bit   hit;
    logic [3:0] er;
    rst = r; req_valid = rv; req_x = xs; req_y = ys; dp_valid = dv; dp_len = dl;
    #1;
    sz  = q.size();
    gid = -1;
    er  = 4'd0;
    hit = WD_EN && (sz != 0) && !dv && (m_wd == TMO - 1);
    if (!r && ((sz < DP) || dv) && !hit) begin
      for (int k = 0; k < NR; k++) begin
        if (gid < 0 && rv[(m_rr + k) % NR]) gid = (m_rr + k) % NR;
      end
    end
    if (gid >= 0) er[gid] = 1'b1;
    last_ready = req_ready;
    chk("req_ready", req_ready, er);
    chk("busy", busy, (sz != 0) || (rv != 4'd0));
    @(posedge clk);
    #1;
    if (r) begin
      q.delete(); m_rr = 0; m_wd = 0; m_spur = 1'b0; m_tmo = 1'b0;
      m_rsp = 4'd0; m_len = 16'd0; m_dpen = 1'b0; m_dpx = 12'd0; m_dpy = 12'd0;
    end else begin
      m_rsp = 4'd0;
      if (dv && sz > 0) begin
        m_rsp[q.pop_front()] = 1'b1;
        m_len = dl;
      end else if (dv) begin
        m_spur = 1'b1;
      end
      m_dpen = (gid >= 0);
      if (gid >= 0) begin
        m_dpx = xs[gid*12 +: 12];
        m_dpy = ys[gid*12 +: 12];
        q.push_back(gid);
        m_rr = (gid + 1) % NR;
      end
      if (hit) begin
        m_tmo = 1'b1; q.delete(); m_wd = 0;
      end else if (WD_EN && sz != 0 && !dv) begin
        m_wd++;
      end else begin
        m_wd = 0;
      end
    end
    chk("dp_en", dp_en, m_dpen);
    chk("dp_x", dp_x, m_dpx);
    chk("dp_y", dp_y, m_dpy);
    chk("rsp_valid", rsp_valid, m_rsp);
    chk("rsp_len", rsp_len, m_len);
    chk("inflight", inflight, q.size());
    chk("err_spur", err_spur, m_spur);
    chk("err_tmo", err_tmo, m_tmo);
  endtask

  initial begin
    int          g;
    vec_t        v;
    logic [3:0]  pend;
    logic [47:0] px;
    logic [47:0] py;
    bit          dv;

    rst = 1'b1; req_valid = 4'd0; req_x = 48'd0; req_y = 48'd0;
    dp_valid = 1'b0; dp_len = 16'd0;
    repeat (2) @(posedge clk);
    #1;

    // Directed table with hand-derived expectations.
    tbl.push_back(mk(1, 4'b1111, 12'd0, 12'd0, 0, 16'd0,  4'b0000, 0, 4'b0000, 16'd0,  4'd0, 0));
    tbl.push_back(mk(0, 4'b0001, 12'd3, 12'd4, 0, 16'd0,  4'b0001, 1, 4'b0000, 16'd0,  4'd1, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 4'b0000, 12'd0, 12'd0, 0, 16'd0, 4'b0000, 0, 4'b0000, 16'd0, 4'd1, 0));
    tbl.push_back(mk(0, 4'b0000, 12'd0, 12'd0, 1, 16'd5,  4'b0000, 0, 4'b0001, 16'd5,  4'd0, 0));
    tbl.push_back(mk(0, 4'b0000, 12'd0, 12'd0, 0, 16'd0,  4'b0000, 0, 4'b0000, 16'd5,  4'd0, 0));
    tbl.push_back(mk(0, 4'b0000, 12'd0, 12'd0, 1, 16'd9,  4'b0000, 0, 4'b0000, 16'd5,  4'd0, 1));
    tbl.push_back(mk(1, 4'b0000, 12'd0, 12'd0, 0, 16'd0,  4'b0000, 0, 4'b0000, 16'd0,  4'd0, 0));
    tbl.push_back(mk(0, 4'b1111, 12'd7, 12'd8, 0, 16'd0,  4'b0001, 1, 4'b0000, 16'd0,  4'd1, 0));
    tbl.push_back(mk(0, 4'b1111, 12'd7, 12'd8, 0, 16'd0,  4'b0010, 1, 4'b0000, 16'd0,  4'd2, 0));
    tbl.push_back(mk(0, 4'b1111, 12'd7, 12'd8, 0, 16'd0,  4'b0100, 1, 4'b0000, 16'd0,  4'd3, 0));
    tbl.push_back(mk(0, 4'b1111, 12'd7, 12'd8, 0, 16'd0,  4'b1000, 1, 4'b0000, 16'd0,  4'd4, 0));
    tbl.push_back(mk(0, 4'b1111, 12'd7, 12'd8, 0, 16'd0,  4'b0001, 1, 4'b0000, 16'd0,  4'd5, 0));
    tbl.push_back(mk(0, 4'b0000, 12'd0, 12'd0, 1, 16'd10, 4'b0000, 0, 4'b0001, 16'd10, 4'd4, 0));
    tbl.push_back(mk(0, 4'b0000, 12'd0, 12'd0, 1, 16'd11, 4'b0000, 0, 4'b0010, 16'd11, 4'd3, 0));
    tbl.push_back(mk(0, 4'b0000, 12'd0, 12'd0, 1, 16'd12, 4'b0000, 0, 4'b0100, 16'd12, 4'd2, 0));
    tbl.push_back(mk(0, 4'b0000, 12'd0, 12'd0, 1, 16'd13, 4'b0000, 0, 4'b1000, 16'd13, 4'd1, 0));
    tbl.push_back(mk(0, 4'b0000, 12'd0, 12'd0, 1, 16'd14, 4'b0000, 0, 4'b0001, 16'd14, 4'd0, 0));
    tbl.push_back(mk(0, 4'b1010, 12'd1, 12'd2, 0, 16'd0,  4'b0010, 1, 4'b0000, 16'd14, 4'd1, 0));
    tbl.push_back(mk(0, 4'b1001, 12'd1, 12'd2, 0, 16'd0,  4'b1000, 1, 4'b0000, 16'd14, 4'd2, 0));
    tbl.push_back(mk(1, 4'b0000, 12'd0, 12'd0, 0, 16'd0,  4'b0000, 0, 4'b0000, 16'd0,  4'd0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      cyc(v.rst, v.rv, {4{v.x}}, {4{v.y}}, v.dv, v.dl, g);
      chk($sformatf("tbl%0d_ready", i), last_ready, v.e_ready);
      chk($sformatf("tbl%0d_dp_en", i), dp_en, v.e_dpen);
      if (v.e_dpen) begin
        chk($sformatf("tbl%0d_dp_x", i), dp_x, v.x);
        chk($sformatf("tbl%0d_dp_y", i), dp_y, v.y);
      end
      chk($sformatf("tbl%0d_rsp_valid", i), rsp_valid, v.e_rsp);
      chk($sformatf("tbl%0d_rsp_len", i), rsp_len, v.e_len);
      chk($sformatf("tbl%0d_inflight", i), inflight, v.e_infl);
      chk($sformatf("tbl%0d_err_spur", i), err_spur, v.e_spur);
    end

    // Fill the FIFO with a stalled datapath, then push and pop together.
    for (int k = 0; k < 8; k++) cyc(0, 4'b0001, {4{12'h0aa}}, {4{12'h055}}, 0, 16'd0, g);
    chk("full_inflight", inflight, 4'd8);
    cyc(0, 4'b0001, {4{12'h0aa}}, {4{12'h055}}, 0, 16'd0, g);
    chk("full_ready", last_ready, 4'b0000);
    chk("full_hold_inflight", inflight, 4'd8);
    cyc(0, 4'b0001, {4{12'h0aa}}, {4{12'h055}}, 1, 16'h0055, g);
    chk("full_pp_ready", last_ready, 4'b0001);
    chk("full_pp_inflight", inflight, 4'd8);
    chk("full_pp_rsp", rsp_valid, 4'b0001);
    chk("full_pp_dp_en", dp_en, 1'b1);
    for (int k = 0; k < 8; k++) cyc(0, 4'b0000, 48'd0, 48'd0, 1, 16'(k), g);
    chk("drain_inflight", inflight, 4'd0);

    // Reset with three tags outstanding, then a late result.
    for (int k = 0; k < 3; k++) cyc(0, 4'b1111, {4{12'h123}}, {4{12'h321}}, 0, 16'd0, g);
    chk("mid_inflight", inflight, 4'd3);
    cyc(1, 4'b1111, {4{12'h123}}, {4{12'h321}}, 1, 16'h00ff, g);
    chk("rst_ready", last_ready, 4'b0000);
    chk("rst_inflight", inflight, 4'd0);
    chk("rst_rsp", rsp_valid, 4'b0000);
    chk("rst_len", rsp_len, 16'd0);
    chk("rst_dp_en", dp_en, 1'b0);
    chk("rst_dp_x", dp_x, 12'd0);
    cyc(0, 4'b0000, 48'd0, 48'd0, 1, 16'd77, g);
    chk("late_spur", err_spur, 1'b1);
    chk("late_rsp", rsp_valid, 4'b0000);
    chk("late_inflight", inflight, 4'd0);
    cyc(1, 4'b0000, 48'd0, 48'd0, 0, 16'd0, g);

    // One issue that never returns.
    cyc(0, 4'b0001, {4{12'd9}}, {4{12'd9}}, 0, 16'd0, g);
    for (int k = 1; k <= 66; k++) begin
      cyc(0, 4'b0000, 48'd0, 48'd0, 0, 16'd0, g);
      if (k == 63) chk("tmo_before", err_tmo, 1'b0);
      if (k == 64) begin
        chk("tmo_at", err_tmo, WD_EN);
        chk("tmo_inflight", inflight, WD_EN ? 4'd0 : 4'd1);
      end
    end
    cyc(1, 4'b0000, 48'd0, 48'd0, 0, 16'd0, g);

    // Random traffic: requests held until granted, in-order datapath replies.
    pend = 4'd0; px = 48'd0; py = 48'd0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 35) begin
          pend[i] = 1'b1;
          px[i*12 +: 12] = 12'($urandom);
          py[i*12 +: 12] = 12'($urandom);
        end
      end
      dv = (q.size() > 0) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 3);
      cyc($urandom_range(0, 199) == 0, pend, px, py, dv, 16'($urandom), g);
      if (g >= 0) pend[g] = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/vlen_sched.md
VLEN_SCHED -- requirements
Module: vlen_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one vector-length datapath.
REQ-002 Parameter DEPTH, default 8, in-flight tag FIFO depth (power of two).
REQ-003 Parameter TMO_CYC, default 64, watchdog limit in cycles.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  NREQ  per-requester request; held until accepted.
REQ-007 req_ready  output  NREQ  combinational grant, at most one bit set.
REQ-008 req_x  input  NREQ*12  packed x operands, slice i for requester i.
REQ-009 req_y  input  NREQ*12  packed y operands, slice i for requester i.
REQ-010 rsp_valid  output  NREQ  one-hot, one-cycle result strobe to owning requester.
REQ-011 rsp_len  output  16  result, qualified by rsp_valid.
REQ-012 dp_en  output  1  one-cycle issue strobe to the shared datapath.
REQ-013 dp_x, dp_y  output  12 each  operands issued with dp_en.
REQ-014 dp_valid  input  1  datapath result strobe; results return in issue order.
REQ-015 dp_len  input  16  datapath result sqrt(x^2+y^2).
REQ-016 inflight  output  $clog2(DEPTH)+1  outstanding issued-not-returned count.
REQ-017 busy  output  1  high when inflight != 0 or any req_valid is high.
REQ-018 err_spur  output  1  sticky: dp_valid seen with no request in flight.
REQ-019 err_tmo  output  1  sticky: watchdog expired.

Function
REQ-020 Grant: when FIFO not full, or full with dp_valid in the same cycle, req_ready selects the first req_valid bit at or after pointer rr_ptr, wrapping modulo NREQ.
REQ-021 Transfer occurs on req_valid[i] & req_ready[i]; rr_ptr updates to (i+1) mod NREQ on transfer, otherwise holds.
REQ-022 On transfer, dp_en, dp_x and dp_y are registered and asserted the next cycle; id i is pushed to the tag FIFO in the same cycle as the transfer.
REQ-023 At most one issue per cycle; back-to-back issues on consecutive cycles are allowed.
REQ-024 On dp_valid with the FIFO non-empty, the head id is popped; the next cycle rsp_valid[id]=1 and rsp_len=dp_len.
REQ-025 dp_valid with the FIFO empty is dropped, sets err_spur, and changes no other state.
REQ-026 Simultaneous push and pop leaves inflight unchanged, including when the FIFO is full.
REQ-027 FIFO read and write pointers wrap modulo DEPTH; full is asserted when inflight==DEPTH.
REQ-028 rsp_len holds its last value when rsp_valid is 0.

Reset
REQ-029 With rst high at a clock edge: req_ready (registered part), rsp_valid, rsp_len, dp_en, dp_x, dp_y, inflight, err_spur and err_tmo are 0; rr_ptr=0; FIFO empty; watchdog=0.
REQ-030 Reset mid-operation discards all in-flight tags; results arriving after reset release are treated as spurious under REQ-025.
REQ-031 req_ready is 0 while rst is high.

Configuration
REQ-032 With VLEN_SCHED_WATCHDOG_EN defined, a counter increments each cycle while inflight!=0 and clears on dp_valid or when inflight==0.
REQ-033 When that counter reaches TMO_CYC, err_tmo sets, the FIFO is flushed (inflight=0) and the counter clears, all in the same cycle.
REQ-034 Without VLEN_SCHED_WATCHDOG_EN, no counter is built and err_tmo is constant 0.

Structure
REQ-035 Package vlen_pkg holds XW=12, LW=16, default NREQ/DEPTH/TMO_CYC constants, and the requester-id typedef.
REQ-036 The round-robin selector is sub-module rr_arb (inputs req and ptr, output one-hot gnt); the tag FIFO is inline.

Verification
REQ-037 Single request: req_valid=4'b0001, x=3, y=4, datapath replies 5 after 6 cycles -> dp_en one cycle after grant, rsp_valid=4'b0001, rsp_len=5.
REQ-038 All four requesters valid continuously, rr_ptr=0 -> grants in order 0,1,2,3,0; each id receives its own result in order.
REQ-039 DEPTH=8, datapath stalled -> eight grants, then req_ready=0 and inflight=8; one dp_valid plus a pending request in the same cycle -> grant issued, inflight stays 8.
REQ-040 dp_valid with inflight=0 -> err_spur=1, no rsp_valid, inflight stays 0.
REQ-041 Macro defined, TMO_CYC=64, one issue with no reply -> err_tmo=1 in cycle 64 after issue, inflight=0; macro undefined -> err_tmo stays 0.
REQ-042 rst asserted with inflight=3 -> all outputs 0 the next cycle; a late dp_valid after release -> err_spur=1.
